// File: rtl/blc_line_tx.sv
// Frames an upstream pixel stream into BLC lines: header, black/active/black body, trailer.
// A new line starts only when the BLC reports ready; lines are counted per frame.
module blc_line_tx #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    BPN_L           = 128,
    parameter int                    READ_PIXEL      = 16,
    parameter int                    BPN_R           = 128,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE       = '0,
    parameter int                    GAP_CYCLES      = 4,
    parameter int                    LINES_PER_FRAME = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  sol,
    output logic                  eol,
    output logic                  frame_done,
    output logic                  busy
);

    localparam logic [15:0] BODY_LEN  = 16'(BPN_L + READ_PIXEL + BPN_R);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] LINE_LAST = 16'(LINES_PER_FRAME - 1);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, HEAD, BODY, TAIL, GAP} state_t;

    state_t      state, state_nx;
    logic [15:0] pix_cnt;
    logic [15:0] line_cnt;
    logic [15:0] gap_cnt;
    logic        xfer;
    logic        last_pix;
    logic        wrap_r;

    assign s_ready  = (state == BODY) && (pix_cnt < BODY_LEN);
    assign xfer     = s_valid && s_ready;
    assign last_pix = xfer && (pix_cnt == BODY_LEN - 16'd1);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (enable) state_nx = WAIT_RDY;
            WAIT_RDY: begin
                if (!enable)      state_nx = IDLE;
                else if (m_ready) state_nx = HEAD;
            end
            HEAD:     state_nx = BODY;
            BODY:     if (last_pix) state_nx = TAIL;
            TAIL:     state_nx = GAP;
            GAP:      if (gap_cnt == GAP_LAST) state_nx = enable ? WAIT_RDY : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // frame_done trails the last line's eol by one cycle, so wrap is remembered from TAIL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            sol        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            gap_cnt    <= '0;
            wrap_r     <= 1'b0;
        end else begin
            m_valid    <= 1'b0;
            sol        <= 1'b0;
            eol        <= 1'b0;
            frame_done <= eol && wrap_r;
            case (state)
                HEAD: begin
                    m_valid <= 1'b1;
                    m_data  <= PAD_VALUE;
                    sol     <= 1'b1;
                    pix_cnt <= '0;
                end
                BODY: begin
                    if (xfer) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        pix_cnt <= pix_cnt + 16'd1;
                    end
                end
                TAIL: begin
                    m_valid <= 1'b1;
                    m_data  <= PAD_VALUE;
                    eol     <= 1'b1;
                    gap_cnt <= '0;
                    if (line_cnt == LINE_LAST) begin
                        line_cnt <= '0;
                        wrap_r   <= 1'b1;
                    end else begin
                        line_cnt <= line_cnt + 16'd1;
                        wrap_r   <= 1'b0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blc_line_tx.sv
// Self-checking bench for blc_line_tx: table-driven line scenarios, hand-written
// enable-drop and mid-line reset sequences, and random-stall lines checked against a framing model.
module tb_blc_line_tx;

    localparam int          DW   = 8;
    localparam int          BODY = 12;
    localparam logic [7:0]  PAD  = 8'hAA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          sol;
    logic          eol;
    logic          frame_done;
    logic          busy;

    always #5 clk = ~clk;

    blc_line_tx #(
        .DATA_WIDTH      (DW),
        .BPN_L           (4),
        .READ_PIXEL      (4),
        .BPN_R           (4),
        .PAD_VALUE       (PAD),
        .GAP_CYCLES      (2),
        .LINES_PER_FRAME (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .sol        (sol),
        .eol        (eol),
        .frame_done (frame_done),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sol;
        logic       eol;
    } beat_t;

    typedef struct packed {
        int stall_mod;
        int rdy_hold;
        int hdr_exp;
        int exp_beats;
    } line_vec_t;

    int    vectors     = 0;
    int    miscompares = 0;
    int    line_idx    = 0;
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // One line: the model expects header, then every accepted pixel in order, then trailer.
    task automatic run_line(input int stall_mod, input int rdy_hold, input bit rnd,
                            input int drop_at, input int abort_at, input int hdr_exp,
                            input int exp_beats);
        int         beats, nsr, hdr_iter, eol_iter, last_x_iter, fd_iter, fd_cnt;
        int         xfers, order_err, gap_err, early_sr;
        logic       prev_sr, prev_x;
        logic [7:0] nv;
        beat_t      b;
        bit         fd_exp;
        beats = 0; nsr = 0; hdr_iter = -1; eol_iter = -1; last_x_iter = -1;
        fd_iter = -1; fd_cnt = 0; xfers = 0; order_err = 0; gap_err = 0; early_sr = 0;
        prev_sr = 1'b0; prev_x = 1'b0; nv = 8'd1;
        fd_exp = (line_idx % 2) == 1;
        exp_q.delete();
        exp_q.push_back('{PAD, 1'b1, 1'b0});
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                beats++;
                if (hdr_iter < 0) hdr_iter = i;
                if (exp_q.size() == 0) begin
                    order_err++;
                end else begin
                    b = exp_q.pop_front();
                    if (m_data !== b.data || sol !== b.sol || eol !== b.eol) order_err++;
                end
                if (eol === 1'b1) eol_iter = i;
            end else if (sol !== 1'b0 || eol !== 1'b0) begin
                order_err++;
            end
            if (prev_sr && (m_valid !== prev_x)) gap_err++;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_iter = i;
            end
            if (eol_iter >= 0 && i > eol_iter) break;
            if (s_ready === 1'b1) begin
                nsr++;
                if (hdr_iter < 0) early_sr++;
            end
            m_ready = (i >= rdy_hold);
            enable  = !(drop_at > 0 && xfers >= drop_at);
            if (rnd) s_valid = ($urandom_range(0, 3) != 0);
            else     s_valid = !(stall_mod > 0 && (i % stall_mod) == stall_mod - 1);
            s_data  = rnd ? 8'($urandom) : nv;
            prev_sr = (s_ready === 1'b1);
            prev_x  = prev_sr && s_valid;
            if (prev_x) begin
                exp_q.push_back('{s_data, 1'b0, 1'b0});
                xfers++;
                nv++;
                last_x_iter = i;
                if (xfers == BODY) exp_q.push_back('{PAD, 1'b0, 1'b1});
            end
            if (abort_at > 0 && xfers == abort_at) begin
                rst_n   = 1'b0;
                enable  = 1'b0;
                m_ready = 1'b0;
                s_valid = 1'b0;
                #1;
                chk("abort_m_valid", 32'(m_valid), 0);
                chk("abort_s_ready", 32'(s_ready), 0);
                chk("abort_busy",    32'(busy),    0);
                chk("abort_m_data",  32'(m_data),  0);
                return;
            end
        end
        chk("line_complete", 32'(eol_iter >= 0), 1);
        chk("beats",         beats, exp_beats);
        chk("order_errors",  order_err, 0);
        chk("model_left",    exp_q.size(), 0);
        chk("valid_gaps",    gap_err, 0);
        chk("early_s_ready", early_sr, 0);
        chk("s_ready_span",  nsr, last_x_iter - hdr_iter + 1);
        chk("eol_position",  eol_iter, last_x_iter + 2);
        if (hdr_exp >= 0) chk("header_latency", hdr_iter, hdr_exp);
        chk("frame_done_count", fd_cnt, fd_exp ? 1 : 0);
        if (fd_exp) chk("frame_done_position", fd_iter, eol_iter + 1);
        line_idx++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        line_vec_t tbl[6];
        int        mv_cnt;
        int        sr_cnt;
        int        r;
        tbl[0] = '{0,  0,  3, 14};
        tbl[1] = '{3,  0,  2, 14};
        tbl[2] = '{0, 20, 22, 14};
        tbl[3] = '{0,  0,  2, 14};
        tbl[4] = '{3,  0,  2, 14};
        tbl[5] = '{0,  3,  5, 14};

        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid",    32'(m_valid),    0);
        chk("rst_m_data",     32'(m_data),     0);
        chk("rst_sol",        32'(sol),        0);
        chk("rst_eol",        32'(eol),        0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_s_ready",    32'(s_ready),    0);
        chk("rst_busy",       32'(busy),       0);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++)
            run_line(tbl[k].stall_mod, tbl[k].rdy_hold, 1'b0, 0, 0, tbl[k].hdr_exp, tbl[k].exp_beats);

        // enable dropped after body pixel 5: line completes, then the FSM parks in IDLE
        run_line(0, 0, 1'b0, 5, 0, 2, 14);
        mv_cnt = 0; sr_cnt = 0;
        m_ready = 1'b1; s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m_valid === 1'b1) mv_cnt++;
            if (s_ready === 1'b1) sr_cnt++;
        end
        chk("idle_no_header", mv_cnt, 0);
        chk("idle_s_ready",   sr_cnt, 0);
        chk("idle_busy",      32'(busy), 0);

        // reset at body pixel 6, then a clean line from IDLE
        run_line(0, 0, 1'b0, 0, 6, 3, 14);
        @(negedge clk);
        rst_n = 1'b1;
        line_idx = 0;
        run_line(0, 0, 1'b0, 0, 0, 3, 14);

        for (int k = 0; k < 6; k++) begin
            r = int'($urandom_range(0, 5));
            run_line(0, r, 1'b1, 0, 0, r + 2, 14);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
